// File: rtl/pingpong_lane_buffer.sv
// pingpong_lane_buffer: two-bank ping-pong beat buffer between a DMA producer and the compute lanes.
// Defining GARUDA_LANEBUF_STATS_EN adds stall_cnt_o, a saturating count of producer stall cycles.
module pingpong_lane_buffer #(
    parameter int NUM_LANES  = 16,
    parameter int LANE_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            in_valid_i,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] in_data_i,
    input  logic                            in_last_i,
    output logic                            in_ready_o,
    output logic                            bank_valid_o,
    output logic                            bank_id_o,
    output logic [$clog2(DEPTH):0]          bank_count_o,
    input  logic                            rd_en_i,
    input  logic [$clog2(DEPTH)-1:0]        rd_addr_i,
    output logic [NUM_LANES*LANE_WIDTH-1:0] rd_data_o,
    output logic                            rd_valid_o,
    input  logic                            release_i
`ifdef GARUDA_LANEBUF_STATS_EN
    ,
    output logic [31:0]                     stall_cnt_o
`endif
);
    localparam int DW = NUM_LANES * LANE_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2;

    logic [1:0][1:0]    state_q, state_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic               wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [DW-1:0]      mem_q [2][DEPTH];
    logic               wr_fire, wr_close, rel_fire, rd_fire;

    assign wr_fire  = in_valid_i && in_ready_o;
    assign wr_close = in_last_i || (cnt_q[wr_bank_q] == CW'(DEPTH - 1));
    assign rel_fire = release_i && bank_valid_o;
    assign rd_fire  = rd_en_i && bank_valid_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= {EMPTY, EMPTY};
            cnt_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // The write bank is never FULL when accepting and the read bank is always FULL when
    // releasing, so a fill completion and a release always touch different banks.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (wr_fire) begin
            cnt_d[wr_bank_q]   = cnt_q[wr_bank_q] + CW'(1);
            state_d[wr_bank_q] = wr_close ? FULL : FILLING;
            wr_bank_d          = wr_close ? ~wr_bank_q : wr_bank_q;
        end
        if (rel_fire) begin
            cnt_d[rd_bank_q]   = '0;
            state_d[rd_bank_q] = EMPTY;
            rd_bank_d          = ~rd_bank_q;
        end
    end

    always_comb begin
        in_ready_o   = state_q[wr_bank_q] != FULL;
        bank_valid_o = state_q[rd_bank_q] == FULL;
        bank_id_o    = rd_bank_q;
        bank_count_o = bank_valid_o ? cnt_q[rd_bank_q] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_bank_q][cnt_q[wr_bank_q][AW-1:0]] <= in_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_fire;
            if (rd_fire) rd_data_o <= ({1'b0, rd_addr_i} < bank_count_o) ? mem_q[rd_bank_q][rd_addr_i] : '0;
        end
    end

`ifdef GARUDA_LANEBUF_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_cnt_o <= '0;
        else if (in_valid_i && !in_ready_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif
endmodule

// File: doc/pingpong_lane_buffer.md
PINGPONG_LANE_BUFFER -- requirements
Module: pingpong_lane_buffer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 16, the number of compute lanes per beat.
REQ-002 SHALL have parameter LANE_WIDTH, default 32, the bits per lane.
REQ-003 SHALL have parameter DEPTH, default 8, the beats per bank; legal values are powers of two >= 2.
REQ-004 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid_i, input, 1 bit: producer (DMA) beat valid.
REQ-007 SHALL have port in_data_i, input, NUM_LANES*LANE_WIDTH bits: wide beat data.
REQ-008 SHALL have port in_last_i, input, 1 bit: beat closes the current bank early.
REQ-009 SHALL have port in_ready_o, output, 1 bit: buffer can accept a beat.
REQ-010 SHALL have port bank_valid_o, output, 1 bit: a full bank is available to the consumer.
REQ-011 SHALL have port bank_id_o, output, 1 bit: index of the consumer-visible bank.
REQ-012 SHALL have port bank_count_o, output, $clog2(DEPTH)+1 bits: beats held in the consumer-visible bank.
REQ-013 SHALL have port rd_en_i, input, 1 bit: read request.
REQ-014 SHALL have port rd_addr_i, input, $clog2(DEPTH) bits: beat index within the visible bank.
REQ-015 SHALL have port rd_data_o, output, NUM_LANES*LANE_WIDTH bits: registered read data.
REQ-016 SHALL have port rd_valid_o, output, 1 bit: rd_data_o valid this cycle.
REQ-017 SHALL have port release_i, input, 1 bit: consumer has finished with the visible bank.

Function
REQ-018 SHALL keep two banks, each with a state (EMPTY, FILLING or FULL) and a beat count; SHALL keep write-bank pointer wr_bank_q and read-bank pointer rd_bank_q.
REQ-019 SHALL drive in_ready_o = 1 exactly when bank wr_bank_q is EMPTY or FILLING; the output SHALL be registered-state-derived, with no combinational path from release_i.
REQ-020 SHALL, on in_valid_i && in_ready_o, write in_data_i to entry [count] of bank wr_bank_q, increment its count and set the state to FILLING.
REQ-021 SHALL, when an accepted beat brings the count to DEPTH or carries in_last_i, set that bank FULL on the next edge and toggle wr_bank_q.
REQ-022 SHALL treat in_last_i on the first beat as a valid one-beat bank (count = 1).
REQ-023 SHALL drive bank_valid_o = (bank rd_bank_q is FULL), bank_id_o = rd_bank_q and bank_count_o = that bank's count; bank_count_o SHALL be 0 when bank_valid_o = 0.
REQ-024 SHALL, on rd_en_i && bank_valid_o at edge t, present rd_data_o = entry rd_addr_i of bank rd_bank_q with rd_valid_o = 1 in cycle t+1 (one-cycle latency).
REQ-025 SHALL return rd_data_o = 0, with rd_valid_o = 1, when rd_addr_i >= bank_count_o.
REQ-026 SHALL ignore rd_en_i while bank_valid_o = 0 (rd_valid_o = 0 next cycle); rd_valid_o SHALL be 0 in any cycle not following an accepted read.
REQ-027 SHALL, on release_i && bank_valid_o, set the visible bank EMPTY, clear its count and toggle rd_bank_q; release_i with bank_valid_o = 0 SHALL be ignored.
REQ-028 SHALL let a release and a bank fill completion on the other bank in the same cycle both take effect.
REQ-029 SHALL, when both banks are FULL, hold in_ready_o = 0 until the cycle after release_i is accepted.
REQ-030 SHALL let rd_data_o hold its last value when no read is accepted.

Reset
REQ-031 SHALL, on rst_ni low at any time, including mid-fill or mid-read, set both banks EMPTY with count 0, wr_bank_q = rd_bank_q = 0, rd_data_o = 0, rd_valid_o = 0, bank_valid_o = 0 and in_ready_o = 1 after release; memory contents are not reset.

Configuration
REQ-032 SHALL, with macro GARUDA_LANEBUF_STATS_EN defined, add output port stall_cnt_o, 32 bits: a saturating count of cycles with in_valid_i && !in_ready_o, reset to 0.
REQ-033 SHALL, without GARUDA_LANEBUF_STATS_EN, omit stall_cnt_o and its counter entirely, with otherwise identical behaviour.

Verification
REQ-034 SHALL cover (DEPTH = 8): 8 beats 0..7 accepted -> next cycle bank_valid_o = 1, bank_id_o = 0, bank_count_o = 8, in_ready_o = 1.
REQ-035 SHALL cover: 3 beats with in_last_i on the third -> bank_count_o = 3; read rd_addr_i = 5 -> rd_data_o = 0, rd_valid_o = 1.
REQ-036 SHALL cover: read rd_addr_i = 2 at edge t after beats 0xA0..0xA7 -> rd_valid_o = 1 and rd_data_o = 0xA2 in cycle t+1.
REQ-037 SHALL cover: 16 beats with no release -> in_ready_o = 0; release_i pulse -> next cycle in_ready_o = 1, bank_id_o = 1.
REQ-038 SHALL cover: reset after 5 beats -> bank_valid_o = 0, in_ready_o = 1; a following 8 beats fill bank 0 with count 8.
REQ-039 SHALL cover: macro defined, 10 cycles of in_valid_i with both banks FULL -> stall_cnt_o = 10; macro undefined -> the design compiles without stall_cnt_o.
